kds_window_buffer: RTL
======================

Name: kds_window_buffer

Overview:
- Parametrised kernel data shifter for the convolution datapath.
- Holds NB_GROUPS groups of KERNEL_SIZE lanes. Each lane is a rotating ring of DEPTH words.
- Each group either loads a fresh kernel column from the input stream or recirculates its stored column, so the PE array can reuse a window without refetching from external memory.
- Adds a valid/ready input handshake, per-group fill tracking, wrap pulses and a synchronous flush.

Parameters:
- DATA_WIDTH, 16, width of one activation word.
- KERNEL_SIZE, 3, lanes per group (one kernel column).
- NB_GROUPS, 12, number of independent groups.
- LOG2_DEPTH, 3, ring depth per lane; DEPTH = 2**LOG2_DEPTH (must be >= 2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- arst_in  in  1  asynchronous reset, active-high.
- in_data  in  KERNEL_SIZE*DATA_WIDTH  new column; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- group_sel  in  NB_GROUPS  groups that load on an input handshake.
- shift_en  in  1  advance every group (recirculate unless loading).
- flush  in  1  synchronous clear of all groups.
- out_data  out  NB_GROUPS*KERNEL_SIZE*DATA_WIDTH  head word of each lane; group g lane k at index (g*KERNEL_SIZE+k).
- out_valid  out  NB_GROUPS  group g is full (DEPTH loads since reset/flush).
- wrap  out  NB_GROUPS  one-cycle pulse: group g completed a full rotation.

Behaviour:
- Per lane, ring r[0..DEPTH-1] of registers; out_data lane = r[0]. No read latency; out_data is combinational from the registers.
- in_ready = (|group_sel) & ~flush. A handshake is hs = in_valid & in_ready.
- Group g advances when (hs & group_sel[g]) | shift_en, and flush = 0.
- On advance: r[i] <= r[i+1] for i < DEPTH-1.
  - r[DEPTH-1] <= in_data lane if the group loads (hs & group_sel[g]).
  - Otherwise r[DEPTH-1] <= r[0] (recirculate).
- Simultaneous hs and shift_en: all groups advance; selected groups load and the rest recirculate. Multiple group_sel bits load the same column into every selected group.
- Fill counter fill[g] (LOG2_DEPTH+1 bits) increments on each load and saturates at DEPTH. out_valid[g] = (fill[g] == DEPTH).
- Loading a full group overwrites the oldest word (r[0] is discarded). fill stays at DEPTH and out_valid stays 1.
- Rotation counter pos[g] (LOG2_DEPTH bits) increments on each advance and wraps modulo DEPTH.
  - wrap[g] is registered: it is 1 in the cycle after an advance that took pos[g] from DEPTH-1 to 0, and 0 otherwise.
- flush = 1: next edge clears all r, fill, pos and wrap to 0. in_ready = 0 in that cycle, and shift_en is ignored.
- Reset (arst_in = 1, at any time including mid-rotation): all r = 0, fill = 0, pos = 0, wrap = 0. Outputs are out_data = 0, out_valid = 0, wrap = 0, and in_ready follows group_sel.
- in_valid without in_ready has no effect. in_data is sampled only on hs.

Optional Feature:
- Macro KDS_ZERO_PAD_EN.
- Defined: adds input port pad_mask (KERNEL_SIZE bits). On a load, lanes with pad_mask[k] = 1 write 0 instead of in_data. This supports feature-map border padding; pad_mask has no effect on recirculation.
- Undefined: port absent and loads write in_data unchanged.

Decomposition:
- Package kds_pkg holds:
  - typedef word_t (DATA_WIDTH logic);
  - typedef column_t (array of KERNEL_SIZE word_t);
  - localparams for default DEPTH and lane index helpers.
- One sub-module kds_ring_lane: a single DEPTH-deep ring with load/advance/data inputs and head output. It is instantiated NB_GROUPS*KERNEL_SIZE times in a generate loop.
- fill/pos counters and wrap stay per group in the top module.

Test Plan:
- Reset then 8 loads into group 0 (group_sel = 0x001), column values {1,2,3}..{22,23,24} -> out_valid = 0x001 after the 8th load; group 0 heads = {1,2,3}; other groups' out_data = 0.
- Full group 0, then 8 cycles of shift_en with in_valid = 0 -> heads cycle {1,2,3},{4,5,6},…,{22,23,24}, then {1,2,3} again; wrap[0] pulses exactly once, 1 cycle after the 8th advance.
- group_sel = 0x000, in_valid = 1 -> in_ready = 0 and no state change. group_sel = 0xFFF with one load of {7,7,7} -> all groups fill = 1 and r[DEPTH-1] = 7.
- Full group 0, then load {99,98,97} with shift_en = 1 on the same cycle -> group 0 head becomes {4,5,6}, the tail is {99,98,97} and out_valid[0] stays 1; unselected full groups recirculate.
- Mid-rotation flush, and separately mid-rotation arst_in pulse -> next cycle out_data = 0, out_valid = 0, wrap = 0; in_ready is 0 during flush.
- With KDS_ZERO_PAD_EN: pad_mask = 3'b101 on a load of {5,6,7} -> stored column {0,6,0}.

Source files
------------

// File: rtl/kds_pkg.sv
// Shared types and helpers for the kernel data shifter (kds_window_buffer).
//
// Contents:
//   word_t / column_t : default-width activation word and kernel column types.
//   DEPTH_DEF         : default ring depth per lane.
//   lane_idx()        : flat lane index of (group, lane) in the out_data bus.
package kds_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int KERNEL_SIZE_DEF = 3;
    localparam int LOG2_DEPTH_DEF  = 3;
    localparam int DEPTH_DEF       = 2 ** LOG2_DEPTH_DEF;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef word_t column_t [KERNEL_SIZE_DEF];

    // Group g lane k sits at flat index g*kernel_size + k on out_data.
    function automatic int lane_idx(input int g, input int k, input int kernel_size);
        return g * kernel_size + k;
    endfunction

endpackage

// File: rtl/kds_ring_lane.sv
// One rotating ring of DEPTH words for a single kernel lane.
//
// Ports:
//   clk, arst_in : clock, asynchronous active-high reset (clears the ring)
//   clear        : synchronous clear of the whole ring (takes priority)
//   advance      : shift the ring by one word towards the head
//   load         : on advance, write load_data into the tail instead of
//                  recirculating the head
//   load_data    : word written into the tail on a load
//   head         : current head word r[0], combinational from the registers
module kds_ring_lane
    import kds_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  arst_in,
    input  logic                  clear,
    input  logic                  advance,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;

    logic [DATA_WIDTH-1:0] ring [DEPTH];

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        end else if (advance) begin
            for (int i = 0; i < DEPTH - 1; i++) ring[i] <= ring[i+1];
            // A load discards the head; otherwise the head wraps to the tail.
            ring[DEPTH-1] <= load ? load_data : ring[0];
        end
    end

    assign head = ring[0];

endmodule

// File: rtl/kds_window_buffer.sv
// Kernel data shifter: NB_GROUPS groups of KERNEL_SIZE rotating lanes. Each
// group either loads a fresh column from the input stream or recirculates
// its stored column so a window can be reused without refetching.
//
// Optional feature macro: KDS_ZERO_PAD_EN adds pad_mask; lanes with
// pad_mask[k] = 1 load zero instead of in_data (border padding).
//
// Ports:
//   clk, arst_in : clock, asynchronous active-high reset
//   in_data      : input column, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid     : in_data valid
//   in_ready     : column accepted this cycle (some group selected, no flush)
//   group_sel    : groups that load on an input handshake
//   shift_en     : advance every group (recirculate unless loading)
//   flush        : synchronous clear of all groups
//   pad_mask     : (KDS_ZERO_PAD_EN only) per-lane zero substitution on load
//   out_data     : head word of every lane, group g lane k at g*KERNEL_SIZE+k
//   out_valid    : group holds DEPTH loaded words since reset/flush
//   wrap         : one-cycle pulse after a group completes a full rotation
module kds_window_buffer
    import kds_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int NB_GROUPS   = 12,
    parameter int LOG2_DEPTH  = LOG2_DEPTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     arst_in,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]        in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [NB_GROUPS-1:0]                     group_sel,
    input  logic                                     shift_en,
    input  logic                                     flush,
`ifdef KDS_ZERO_PAD_EN
    input  logic [KERNEL_SIZE-1:0]                   pad_mask,
`endif
    output logic [NB_GROUPS*KERNEL_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [NB_GROUPS-1:0]                     out_valid,
    output logic [NB_GROUPS-1:0]                     wrap
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0]   FILL_FULL = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH-1:0] POS_LAST  = '1;

    logic                            hs;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] load_col;

    // Flush blocks the handshake so nothing is accepted in the clearing cycle.
    assign in_ready = (|group_sel) & ~flush;
    assign hs       = in_valid & in_ready;

`ifdef KDS_ZERO_PAD_EN
    always_comb begin
        load_col = in_data;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            if (pad_mask[k]) load_col[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end
`else
    assign load_col = in_data;
`endif

    for (genvar g = 0; g < NB_GROUPS; g++) begin : g_group
        logic                  load_g;
        logic                  adv_g;
        logic [LOG2_DEPTH:0]   fill_q;
        logic [LOG2_DEPTH-1:0] pos_q;
        logic                  wrap_q;

        assign load_g = hs & group_sel[g];
        assign adv_g  = (load_g | shift_en) & ~flush;

        always_ff @(posedge clk or posedge arst_in) begin
            if (arst_in) begin
                fill_q <= '0;
                pos_q  <= '0;
                wrap_q <= 1'b0;
            end else if (flush) begin
                fill_q <= '0;
                pos_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                // Loading a full group overwrites the oldest word; fill saturates.
                if (load_g && fill_q != FILL_FULL) fill_q <= fill_q + (LOG2_DEPTH+1)'(1);
                if (adv_g) pos_q <= pos_q + LOG2_DEPTH'(1);
                wrap_q <= adv_g && (pos_q == POS_LAST);
            end
        end

        assign out_valid[g] = (fill_q == FILL_FULL);
        assign wrap[g]      = wrap_q;

        for (genvar k = 0; k < KERNEL_SIZE; k++) begin : g_lane
            localparam int L = lane_idx(g, k, KERNEL_SIZE);

            kds_ring_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .LOG2_DEPTH (LOG2_DEPTH)
            ) u_lane (
                .clk       (clk),
                .arst_in   (arst_in),
                .clear     (flush),
                .advance   (adv_g),
                .load      (load_g),
                .load_data (load_col[k*DATA_WIDTH +: DATA_WIDTH]),
                .head      (out_data[L*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    end

endmodule
